lifo_stack: RTL

Parameterised LIFO stack for the FA4 datapath. It holds call and return addresses and spilled operands. It is the general-purpose replacement for the fixed-behaviour stack, adding:
- a registered pop port with a valid strobe
- a combinational peek of the top entry
- simultaneous push and pop
- a selectable full-stack policy (overwrite oldest or reject)
- sticky overflow and underflow error flags

It sits between the control FSM and the register file, and is driven one operation per clock.

---
 rtl/lifo_stack.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parameterised LIFO stack with registered pop port, peek and sticky error flags
module lifo_stack #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 16,
    parameter bit OVERWRITE = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset_L,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             mem_we;
    logic [PW-1:0]    mem_waddr;
    logic [PW-1:0]    top_idx;
    logic             empty_w, full_w;

    // ptr is the next free slot, so the newest entry sits one below it (mod DEPTH).
    assign top_idx = ptr_q - PW'(1);
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    // Next-state decode, priority clear > push&pop > pop > push.
    always_comb begin
        ptr_d       = ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        if (clear) begin
            ptr_d       = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (push && pop) begin
            out_valid_d = 1'b1;
            if (empty_w) begin
                // Nothing stored: the pushed value goes straight out.
                data_out_d = data_in;
            end else begin
                data_out_d = mem_q[top_idx];
                mem_we     = 1'b1;
                mem_waddr  = top_idx;
            end
        end else if (pop) begin
            if (empty_w) begin
                underflow_d = 1'b1;
            end else begin
                data_out_d  = mem_q[top_idx];
                ptr_d       = top_idx;
                count_d     = count_q - CW'(1);
                out_valid_d = 1'b1;
            end
        end else if (push) begin
            if (!full_w) begin
                mem_we  = 1'b1;
                ptr_d   = ptr_q + PW'(1);
                count_d = count_q + CW'(1);
            end else begin
                overflow_d = 1'b1;
                if (OVERWRITE) begin
                    // When full, the slot at ptr holds the oldest entry.
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + PW'(1);
                end
            end
        end
    end

    // Control and output registers, asynchronously reset.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            ptr_q       <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage; contents are don't-care while empty so no reset is needed.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign top       = empty_w ? '0 : mem_q[top_idx];
    assign count     = count_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
